// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher_pkg: dispatcher FSM states and default parameter values
package cmd_dispatcher_pkg;
  localparam int N_CH_DEF    = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int CMD_W_DEF   = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 1000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_e;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: request queue with wrap-bit pointers; caller guarantees no push when full without pop
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: queues received {addr,cmd} frames and issues them one at a time to sensor channels
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [CMD_W-1:0]  rx_cmd,
  output logic [N_CH-1:0]   ch_req,
  output logic [CMD_W-1:0]  ch_cmd,
  input  logic [N_CH-1:0]   ch_ack,
  output logic              err_addr,
  output logic              err_timeout,
  output logic              err_ovf,
  output logic              busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] NCH = (ADDR_W + 1)'(N_CH);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CMD_W-1:0] cmd_q;
  logic [N_CH-1:0] req_q, req_d, sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_addr_q, err_addr_d, err_to_q, err_to_d, err_ovf_q, err_ovf_d;
  logic addr_ok, push, pop, full, empty, hit, expire, done;
  logic [ADDR_W+CMD_W-1:0] head;
  cmd_fifo #(.WIDTH(ADDR_W + CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din({rx_addr, rx_cmd}), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    addr_ok = {1'b0, rx_addr} < NCH;
    pop = state_q == IDLE && !empty;
    push = rx_ready && addr_ok && (!full || pop);
    sel = N_CH'(1) << addr_q;
    hit = state_q == WAIT_ACK && |(ch_ack & sel);
    expire = state_q == WAIT_ACK && cnt_q == CNT_W'(TIMEOUT - 1);
    done = hit || expire;
    state_d = state_q == IDLE ? (empty ? IDLE : ISSUE) :
              state_q == ISSUE ? WAIT_ACK :
              (state_q == WAIT_ACK && !done) ? WAIT_ACK : IDLE;
    req_d = state_q == ISSUE ? sel : (state_q == WAIT_ACK && !done) ? req_q : '0;
    cnt_d = (state_q == WAIT_ACK && !done) ? cnt_q + 1'b1 : '0;
    err_addr_d = rx_ready && !addr_ok;
    err_ovf_d = rx_ready && addr_ok && full && !pop;
    // ack wins over a timeout landing in the same cycle
    err_to_d = expire && !hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cmd_q      <= '0;
      req_q      <= '0;
      cnt_q      <= '0;
      err_addr_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (pop) {addr_q, cmd_q} <= head;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
      err_to_q   <= err_to_d;
      err_ovf_q  <= err_ovf_d;
    end
  end
  assign ch_req      = req_q;
  assign ch_cmd      = cmd_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_to_q;
  assign err_ovf     = err_ovf_q;
  assign busy        = !empty || state_q != IDLE;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: random and directed frames scored against a queue/timing reference model
module tb_cmd_dispatcher;
  localparam int NC = 9, AW = 5, CW = 8, DP = 4, TO = 16;
  logic clk = 0, rst_n = 0, rx_ready = 0;
  logic [AW-1:0] rx_addr = '0;
  logic [CW-1:0] rx_cmd = '0;
  logic [NC-1:0] ch_req, ch_ack = '0;
  logic [CW-1:0] ch_cmd;
  logic err_addr, err_timeout, err_ovf, busy;
  cmd_dispatcher #(.N_CH(NC), .ADDR_W(AW), .CMD_W(CW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_addr(rx_addr), .rx_cmd(rx_cmd),
    .ch_req(ch_req), .ch_cmd(ch_cmd), .ch_ack(ch_ack), .err_addr(err_addr),
    .err_timeout(err_timeout), .err_ovf(err_ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int addr; int cmd; int d;} frame_t;
  typedef struct {int addr; int cmd; int cyc;} disp_t;
  frame_t mq[$];
  disp_t sb_d[$];
  int q_ea[$], q_eo[$], q_et[$];
  int cyc = 0, checks = 0, passes = 0;
  int free_edge = 0, ack_edge = -1, cur_addr = 0;
  bit exp_busy = 0;
  disp_t x;
  logic [NC-1:0] prev_req = '0;
  logic [CW-1:0] prev_cmd = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  // monitor: every request rise and error pulse must match the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) prev_req = '0;
    else begin
      if ($countones(ch_req) > 1) chk("req_onehot", $countones(ch_req), 1);
      if (ch_req != 0 && prev_req == 0) begin
        if (sb_d.size() == 0) chk("unexpected_req", ch_req, 0);
        else begin
          x = sb_d.pop_front();
          chk("req_chan", ch_req, longint'(1) << x.addr);
          chk("req_cmd", ch_cmd, x.cmd);
          chk("req_cycle", cyc, x.cyc);
        end
      end else if (ch_req != 0 && (ch_req != prev_req || ch_cmd != prev_cmd))
        chk("req_hold", {ch_req, ch_cmd}, {prev_req, prev_cmd});
      if (err_addr) chk("err_addr_cycle", cyc, q_ea.size() > 0 ? q_ea.pop_front() : -1);
      if (err_ovf) chk("err_ovf_cycle", cyc, q_eo.size() > 0 ? q_eo.pop_front() : -1);
      if (err_timeout) chk("err_timeout_cycle", cyc, q_et.size() > 0 ? q_et.pop_front() : -1);
      prev_req = ch_req;
      prev_cmd = ch_cmd;
    end
  end
  // one clock: check busy, then plan the next edge from the model and drive inputs for it
  task automatic step(input bit v, input int a, input int c, input int d);
    int n;
    frame_t f;
    disp_t dx;
    @(posedge clk);
    #1;
    chk("busy", busy, exp_busy);
    n = cyc + 1;
    if (n >= free_edge && mq.size() > 0) begin
      f = mq.pop_front();
      cur_addr = f.addr;
      ack_edge = f.d < TO ? n + 2 + f.d : -1;
      free_edge = n + 3 + (f.d < TO ? f.d : TO - 1);
      dx = '{f.addr, f.cmd, n + 1};
      sb_d.push_back(dx);
      if (f.d >= TO) q_et.push_back(n + 1 + TO);
    end
    rx_ready = v;
    rx_addr = AW'(a);
    rx_cmd = CW'(c);
    if (v) begin
      f = '{a, c, d};
      if (a >= NC) q_ea.push_back(n);
      else if (mq.size() < DP) mq.push_back(f);
      else q_eo.push_back(n);
    end
    ch_ack = (NC'($urandom) & ~(NC'(1) << cur_addr)) | (n == ack_edge ? NC'(1) << cur_addr : '0);
    exp_busy = mq.size() > 0 || n < free_edge - 1;
  endtask
  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 0);
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    rx_ready = 0;
    ch_ack = '0;
    #1;
    chk("rst_req", ch_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", ch_cmd, 0);
    mq.delete(); sb_d.delete(); q_ea.delete(); q_eo.delete(); q_et.delete();
    free_edge = 0; ack_edge = -1; exp_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  function automatic int rnd_d();
    int r = $urandom_range(0, 9);
    return r == 0 ? 3 * TO : r == 1 ? TO - 1 : int'($urandom_range(0, 4));
  endfunction
  function automatic int rnd_a();
    return $urandom_range(0, 7) == 0 ? int'($urandom_range(NC, 31)) : int'($urandom_range(0, NC - 1));
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", ch_req, 0);
    chk("reset_cmd", ch_cmd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_errs", {err_addr, err_timeout, err_ovf}, 0);
    rst_n = 1;
    step(1, 3, 'hA5, 2);
    idle(10);
    step(1, 12, 'h3C, 0);
    idle(4);
    step(1, 5, 'h5A, 1000);
    idle(25);
    step(1, 7, 'h77, TO - 1);
    idle(25);
    for (int i = 0; i < 6; i++) step(1, i, 'h40 + i, 8);
    idle(80);
    step(1, 2, 'h22, 6);
    idle(15);
    for (int i = 0; i < 1500; i++)
      if ($urandom_range(0, 2) == 0) step(1, rnd_a(), int'($urandom_range(0, 255)), rnd_d());
      else step(0, 0, 0, 0);
    idle(150);
    step(1, 2, 'h11, 100);
    step(1, 4, 'h22, 100);
    step(1, 6, 'h33, 100);
    idle(6);
    chk("pre_rst_req_active", ch_req != 0, 1);
    do_reset();
    idle(30);
    chk("pending_dispatch", sb_d.size(), 0);
    chk("pending_err_addr", q_ea.size(), 0);
    chk("pending_err_ovf", q_eo.size(), 0);
    chk("pending_err_timeout", q_et.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
